sipo_align_ctrl: RTL and testbench

Word-alignment controller for the simple_serdes receive path. It runs on the SIPO parallel clock and takes the unaligned parallel words and the parallel lock. It searches all bit rotations for a repeating training pattern, confirms the chosen rotation, and then presents aligned words downstream. It also supervises the link: it re-aligns on sustained decode errors, drops to idle on loss of lock, and declares failure if no rotation ever matches.

---
 rtl/sipo_align_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sipo_align_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sipo_align_ctrl
// Brief   : Word aligner for the SIPO receive path; sweeps bit rotations for a
//           training word, confirms it, then supervises the aligned link.
// Revision: 1.0
// ============================================================================
module sipo_align_ctrl #(
    parameter int                PWIDTH        = 20,
    parameter logic [PWIDTH-1:0] TRAIN_PATTERN = 20'hFFC00,
    parameter int                LOCK_CNT      = 16,
    parameter int                MAX_SWEEPS    = 4,
    parameter int                ERR_MAX       = 8,
    localparam int               CW            = $clog2(PWIDTH)
) (
    input  logic              i_pclk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_plock,
    input  logic [PWIDTH-1:0] i_pdata,
    input  logic              i_rerr,
    output logic [PWIDTH-1:0] o_data,
    output logic              o_valid,
    output logic              o_aligned,
    output logic              o_fail,
    output logic [CW-1:0]     o_offset,
    output logic [7:0]        o_realign_cnt
);

    localparam int MCW = $clog2(LOCK_CNT + 1);
    localparam int SCW = $clog2(MAX_SWEEPS + 1);
    localparam int ECW = $clog2(ERR_MAX + 1);

    localparam logic [CW-1:0]  OFF_LAST   = CW'(PWIDTH - 1);
    localparam logic [MCW-1:0] LOCK_LAST  = MCW'(LOCK_CNT - 1);
    localparam logic [SCW-1:0] SWEEP_LAST = SCW'(MAX_SWEEPS - 1);
    localparam logic [ECW-1:0] ERR_LAST   = ECW'(ERR_MAX - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_ALIGNED = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    state_t              state_q;
    logic [PWIDTH-1:0]   cur_q;
    logic [PWIDTH-1:0]   prev_q;
    logic [PWIDTH-1:0]   data_q;
    logic                valid_q;
    logic [CW-1:0]       offset_q;
    logic [CW-1:0]       offset_d;
    logic [SCW-1:0]      sweep_q;
    logic [SCW-1:0]      sweep_d;
    logic [MCW-1:0]      match_cnt_q;
    logic [ECW-1:0]      err_cnt_q;
    logic [7:0]          realign_q;

    logic [2*PWIDTH-1:0] w_window;
    logic [2*PWIDTH-1:0] w_shifted;
    logic [PWIDTH-1:0]   w_cand;
    logic                w_match;
    logic                w_wrap;
    logic                w_sweep_done;

    // Shifting left by the offset brings candidate bit k..k+PWIDTH-1 to the top.
    assign w_window     = {prev_q, cur_q};
    assign w_shifted    = w_window << offset_q;
    assign w_cand       = w_shifted[2*PWIDTH-1 -: PWIDTH];
    assign w_match      = (w_cand == TRAIN_PATTERN);

    assign w_wrap       = (offset_q == OFF_LAST);
    assign offset_d     = w_wrap ? '0 : offset_q + CW'(1);
    assign sweep_d      = w_wrap ? sweep_q + SCW'(1) : sweep_q;
    assign w_sweep_done = w_wrap && (sweep_q == SWEEP_LAST);

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            prev_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            offset_q    <= '0;
            sweep_q     <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            realign_q   <= '0;
        end else begin
            cur_q   <= i_pdata;
            prev_q  <= cur_q;
            data_q  <= w_cand;
            valid_q <= (state_q == ST_ALIGNED);

            if (!i_en || !i_plock) begin
                state_q     <= ST_IDLE;
                offset_q    <= '0;
                sweep_q     <= '0;
                match_cnt_q <= '0;
                err_cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        offset_q    <= '0;
                        sweep_q     <= '0;
                        match_cnt_q <= '0;
                        err_cnt_q   <= '0;
                        state_q     <= ST_SEARCH;
                    end
                    ST_SEARCH: begin
                        if (w_match) begin
                            match_cnt_q <= MCW'(1);
                            state_q     <= ST_VERIFY;
                        end else begin
                            offset_q <= offset_d;
                            sweep_q  <= sweep_d;
                            if (w_sweep_done) state_q <= ST_FAIL;
                        end
                    end
                    ST_VERIFY: begin
                        if (w_match) begin
                            match_cnt_q <= match_cnt_q + MCW'(1);
                            if (match_cnt_q == LOCK_LAST) state_q <= ST_ALIGNED;
                        end else begin
                            match_cnt_q <= '0;
                            offset_q    <= offset_d;
                            sweep_q     <= sweep_d;
                            state_q     <= w_sweep_done ? ST_FAIL : ST_SEARCH;
                        end
                    end
                    ST_ALIGNED: begin
                        if (!i_rerr) begin
                            err_cnt_q <= '0;
                        end else if (err_cnt_q == ERR_LAST) begin
                            state_q     <= ST_SEARCH;
                            offset_q    <= '0;
                            sweep_q     <= '0;
                            match_cnt_q <= '0;
                            err_cnt_q   <= '0;
                            if (realign_q != 8'hFF) realign_q <= realign_q + 8'd1;
                        end else begin
                            err_cnt_q <= err_cnt_q + ECW'(1);
                        end
                    end
                    ST_FAIL: begin
                        state_q <= ST_FAIL;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_aligned     = (state_q == ST_ALIGNED);
    assign o_fail        = (state_q == ST_FAIL);
    assign o_offset      = offset_q;
    assign o_realign_cnt = realign_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sipo_align_ctrl
// Brief   : Directed self-checking bench for sipo_align_ctrl.
// Revision: 1.0
// ============================================================================
module tb_sipo_align_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic        i_plock;
    logic [19:0] i_pdata;
    logic        i_rerr;
    logic [19:0] o_data;
    logic        o_valid;
    logic        o_aligned;
    logic        o_fail;
    logic [4:0]  o_offset;
    logic [7:0]  o_realign_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    sipo_align_ctrl dut (
        .i_pclk        (clk),
        .i_rst         (rst),
        .i_en          (i_en),
        .i_plock       (i_plock),
        .i_pdata       (i_pdata),
        .i_rerr        (i_rerr),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_aligned     (o_aligned),
        .o_fail        (o_fail),
        .o_offset      (o_offset),
        .o_realign_cnt (o_realign_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Fill the capture pipeline with the stream while held idle, then enable.
    task automatic start(input logic [19:0] w);
        i_en    = 1'b0;
        i_plock = 1'b1;
        i_rerr  = 1'b0;
        i_pdata = w;
        step();
        step();
        i_en = 1'b1;
        cyc  = 0;
    endtask

    initial begin
        // Reset with arbitrary inputs
        rst     = 1'b1;
        i_en    = 1'b1;
        i_plock = 1'b1;
        i_rerr  = 1'b1;
        i_pdata = 20'(($urandom));
        step();
        i_pdata = 20'(($urandom));
        step();
        chk("rst_data",    32'(o_data), 32'h0);
        chk("rst_valid",   32'(o_valid), 32'h0);
        chk("rst_aligned", 32'(o_aligned), 32'h0);
        chk("rst_fail",    32'(o_fail), 32'h0);
        chk("rst_offset",  32'(o_offset), 32'h0);
        chk("rst_realign", 32'(o_realign_cnt), 32'h0);
        rst = 1'b0;

        // Pattern already at offset 0
        start(20'hFFC00);
        for (int c = 1; c <= 22; c++) begin
            step();
            chk("s2_offset",  32'(o_offset), 32'h0);
            chk("s2_aligned", 32'(o_aligned), 32'(c >= 17));
            chk("s2_valid",   32'(o_valid), 32'(c >= 18));
            if (c >= 18) chk("s2_data", 32'(o_data), 32'h000FFC00);
        end

        // Error bursts while aligned
        i_rerr = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk("s5_burst7_aligned", 32'(o_aligned), 32'h1);
        end
        i_rerr = 1'b0;
        step();
        chk("s5_gap_aligned", 32'(o_aligned), 32'h1);
        i_rerr = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk("s5_burst8_aligned", 32'(o_aligned), 32'h1);
        end
        step();
        chk("s5_realign_aligned", 32'(o_aligned), 32'h0);
        chk("s5_realign_offset",  32'(o_offset), 32'h0);
        chk("s5_realign_cnt",     32'(o_realign_cnt), 32'h1);
        chk("s5_valid_lag",       32'(o_valid), 32'h1);
        i_rerr = 1'b0;
        step();
        chk("s5_valid_low", 32'(o_valid), 32'h0);
        for (int t = 2; t <= 16; t++) begin
            step();
            chk("s5_reacq_aligned", 32'(o_aligned), 32'(t >= 16));
        end

        // Drop enable while aligned; realign count survives
        i_en = 1'b0;
        step();
        chk("s5_en_drop_aligned", 32'(o_aligned), 32'h0);
        chk("s5_en_drop_valid",   32'(o_valid), 32'h1);
        chk("s5_en_drop_realign", 32'(o_realign_cnt), 32'h1);
        step();
        chk("s5_en_drop_valid2",  32'(o_valid), 32'h0);

        // All-zero stream sweeps until failure
        start(20'h00000);
        for (int c = 1; c <= 81; c++) begin
            step();
            chk("s4_offset", 32'(o_offset), (c <= 1) ? 32'h0 : 32'((c - 1) % 20));
            chk("s4_fail",   32'(o_fail), 32'(c >= 81));
        end
        chk("s4_realign_kept", 32'(o_realign_cnt), 32'h1);
        i_en = 1'b0;
        step();
        chk("s4_fail_cleared", 32'(o_fail), 32'h0);
        chk("s4_idle_aligned", 32'(o_aligned), 32'h0);

        // Stream rotated so the pattern sits at offset 7
        do_reset();
        chk("s3_realign_reset", 32'(o_realign_cnt), 32'h0);
        start(20'h01FF8);
        for (int c = 1; c <= 28; c++) begin
            step();
            chk("s3_offset",  32'(o_offset), (c <= 1) ? 32'h0 : ((c <= 8) ? 32'(c - 1) : 32'h7));
            chk("s3_aligned", 32'(o_aligned), 32'(c >= 24));
            if (c >= 25) chk("s3_data", 32'(o_data), 32'h000FFC00);
        end

        // Lock loss during verification, then full re-acquisition
        do_reset();
        start(20'hFFC00);
        for (int c = 1; c <= 6; c++) begin
            step();
            chk("s6_pre_aligned", 32'(o_aligned), 32'h0);
        end
        i_plock = 1'b0;
        step();
        chk("s6_drop_aligned", 32'(o_aligned), 32'h0);
        chk("s6_drop_offset",  32'(o_offset), 32'h0);
        i_plock = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 19; c++) begin
            step();
            chk("s6_aligned", 32'(o_aligned), 32'(c >= 17));
            if (c >= 18) chk("s6_data", 32'(o_data), 32'h000FFC00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
